// File: rtl/div_pkg.sv
// Shared types and constants for the Newton-Raphson divider control FSM.
package div_pkg;

    localparam int unsigned ITERS_DEFAULT = 4;
    localparam int unsigned CNT_W         = 3;
    localparam int unsigned IA_W          = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEED_D = 3'd1,
        SEED_N = 3'd2,
        ITER_D = 3'd3,
        ITER_N = 3'd4,
        DONE   = 3'd5
    } state_t;

    // rightMux select codes for the initial-approximation table
    localparam logic [1:0] RM_IA0  = 2'b00;
    localparam logic [1:0] RM_IA1  = 2'b01;
    localparam logic [1:0] RM_IA2  = 2'b10;
    localparam logic [1:0] RM_IA3  = 2'b11;
    localparam logic [1:0] RM_NONE = 2'b00;

    // Reciprocal seeds in Q1.15: 0.9, 0.73, 0.62, 0.54
    localparam logic [IA_W-1:0] IA0_VAL = 16'h7333;
    localparam logic [IA_W-1:0] IA1_VAL = 16'h5D71;
    localparam logic [IA_W-1:0] IA2_VAL = 16'h4F5C;
    localparam logic [IA_W-1:0] IA3_VAL = 16'h451F;

    typedef struct packed {
        logic       ksave;
        logic       dsave;
        logic       nsave;
        logic       knextsel;
        logic [1:0] rightmux;
        logic       busy;
        logic       done;
        logic       err;
    } ctrl_t;

endpackage

// File: rtl/div_control.sv
// Sequencer for an iterative (Goldschmidt-style) divider datapath: seed pair,
// ITERS refinement pairs, then a one-cycle done/err pulse.
module div_control
    import div_pkg::*;
#(
    parameter int unsigned ITERS = ITERS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] divisor,
    output logic        kSave,
    output logic        dSave,
    output logic        nSave,
    output logic        kNextSel,
    output logic [1:0]  rightMux,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             err_q, err_d;
    ctrl_t            ctrl_q, ctrl_d;

    // Only the top three divisor bits steer the sequence
    logic divisor_unused_c;
    assign divisor_unused_c = ^divisor[12:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Next state plus outputs decoded from the next state, so the registered
    // outputs always match a pure decode of the current state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        err_d   = err_q;
        ctrl_d  = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = divisor[14:13];
                    err_d   = ~divisor[15];
                    state_d = divisor[15] ? SEED_D : DONE;
                end
            end
            SEED_D: state_d = SEED_N;
            SEED_N: begin
                cnt_d   = '0;
                state_d = ITER_D;
            end
            ITER_D: state_d = ITER_N;
            ITER_N: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = (cnt_q == LAST_ITER) ? DONE : ITER_D;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        case (state_d)
            SEED_D: begin
                ctrl_d.ksave    = 1'b1;
                ctrl_d.dsave    = 1'b1;
                ctrl_d.knextsel = 1'b1;
                ctrl_d.rightmux = idx_d;
                ctrl_d.busy     = 1'b1;
            end
            SEED_N: begin
                ctrl_d.nsave    = 1'b1;
                ctrl_d.knextsel = 1'b1;
                ctrl_d.rightmux = idx_d;
                ctrl_d.busy     = 1'b1;
            end
            ITER_D: begin
                ctrl_d.ksave    = 1'b1;
                ctrl_d.dsave    = 1'b1;
                ctrl_d.rightmux = RM_NONE;
                ctrl_d.busy     = 1'b1;
            end
            ITER_N: begin
                ctrl_d.nsave    = 1'b1;
                ctrl_d.rightmux = RM_NONE;
                ctrl_d.busy     = 1'b1;
            end
            DONE: begin
                ctrl_d.busy = 1'b1;
                ctrl_d.done = 1'b1;
                ctrl_d.err  = err_d;
            end
            default: ctrl_d = '0;
        endcase
    end

    assign kSave    = ctrl_q.ksave;
    assign dSave    = ctrl_q.dsave;
    assign nSave    = ctrl_q.nsave;
    assign kNextSel = ctrl_q.knextsel;
    assign rightMux = ctrl_q.rightmux;
    assign busy     = ctrl_q.busy;
    assign done     = ctrl_q.done;
    assign err      = ctrl_q.err;

endmodule

// File: tb/tb_div_control.sv
// Self-checking bench for div_control: ITERS=4 and ITERS=1 instances share
// stimulus and are compared every cycle against a run-position model.
module tb_div_control;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] divisor;

    logic       ks[2], ds[2], ns[2], kn[2], bs[2], dn[2], eo[2];
    logic [1:0] rm[2];

    div_control #(.ITERS(4)) dut0 (
        .clk(clk), .reset(reset), .start(start), .divisor(divisor),
        .kSave(ks[0]), .dSave(ds[0]), .nSave(ns[0]), .kNextSel(kn[0]),
        .rightMux(rm[0]), .busy(bs[0]), .done(dn[0]), .err(eo[0])
    );

    div_control #(.ITERS(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .divisor(divisor),
        .kSave(ks[1]), .dSave(ds[1]), .nSave(ns[1]), .kNextSel(kn[1]),
        .rightMux(rm[1]), .busy(bs[1]), .done(dn[1]), .err(eo[1])
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: whether a run is active, which cycle of the run we are in
    // (1 = first cycle after the accepting edge), and the latched operand info.
    bit       run[2];
    int       k[2];
    bit [1:0] idx[2];
    bit       er[2];
    int       iters_m[2] = '{4, 1};

    function automatic logic [8:0] expect_out(int i);
        logic [8:0] e;
        int last;
        e = '0;
        last = 3 + 2 * iters_m[i];
        if (!run[i]) return e;
        e[2] = 1'b1;
        if (er[i]) begin
            e[1] = 1'b1;
            e[0] = 1'b1;
        end else if (k[i] == 1) begin
            e[8] = 1'b1; e[7] = 1'b1; e[5] = 1'b1; e[4:3] = idx[i];
        end else if (k[i] == 2) begin
            e[6] = 1'b1; e[5] = 1'b1; e[4:3] = idx[i];
        end else if (k[i] < last) begin
            if (k[i] % 2 == 1) begin
                e[8] = 1'b1; e[7] = 1'b1;
            end else begin
                e[6] = 1'b1;
            end
        end else begin
            e[1] = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [8:0] actual(int i);
        return {ks[i], ds[i], ns[i], kn[i], rm[i], bs[i], dn[i], eo[i]};
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                run[i] = 1'b0;
            end else if (!run[i]) begin
                if (start) begin
                    run[i] = 1'b1;
                    k[i]   = 1;
                    idx[i] = divisor[14:13];
                    er[i]  = ~divisor[15];
                end
            end else if (er[i] || k[i] == 3 + 2 * iters_m[i]) begin
                run[i] = 1'b0;
            end else begin
                k[i] = k[i] + 1;
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int i = 0; i < 2; i++)
            check($sformatf("%s dut%0d outputs", tag, i), int'(actual(i)), int'(expect_out(i)));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs("cycle");
    endtask

    task automatic async_reset_pulse();
        #2;
        reset = 1'b1;
        run[0] = 1'b0;
        run[1] = 1'b0;
        #1;
        check_outputs("async reset");
        tick();
        reset = 1'b0;
    endtask

    // Accept one run, then watch up to 16 cycles; start re-pulsed in cycles ra/rb.
    task automatic run_vec(input logic [15:0] d, input int ra, input int rb,
                           output int lat0, output int lat1, output logic [1:0] rm0,
                           output logic e0, output int ndone0);
        divisor = d;
        start = 1'b1;
        tick();
        start = 1'b0;
        divisor = ~d;
        lat0 = -1; lat1 = -1; ndone0 = 0; e0 = 1'b0;
        rm0 = rm[0];
        for (int c = 1; c <= 16; c++) begin
            if (dn[0] === 1'b1) begin
                if (lat0 < 0) lat0 = c;
                ndone0++;
                e0 = eo[0];
            end
            if (dn[1] === 1'b1 && lat1 < 0) lat1 = c;
            start = (c == ra || c == rb);
            tick();
        end
        start = 1'b0;
        repeat (4) tick();
    endtask

    typedef struct {
        logic [15:0] d;
        logic [1:0]  rm;
        logic        er;
        int          lat0;
        int          lat1;
    } vec_t;

    initial begin
        vec_t vt[8];
        int lat0, lat1, nd, last, cnt;
        logic [1:0] r0;
        logic e0;

        vt[0] = '{16'hC000, 2'b10, 1'b0, 11, 5};
        vt[1] = '{16'h4000, 2'b00, 1'b1, 1, 1};
        vt[2] = '{16'h8000, 2'b00, 1'b0, 11, 5};
        vt[3] = '{16'hA000, 2'b01, 1'b0, 11, 5};
        vt[4] = '{16'hE123, 2'b11, 1'b0, 11, 5};
        vt[5] = '{16'hFFFF, 2'b11, 1'b0, 11, 5};
        vt[6] = '{16'h0000, 2'b00, 1'b1, 1, 1};
        vt[7] = '{16'h7FFF, 2'b00, 1'b1, 1, 1};

        reset = 1'b0; start = 1'b0; divisor = '0;
        run[0] = 0; run[1] = 0; k[0] = 0; k[1] = 0;
        #1 reset = 1'b1;
        #1 check_outputs("reset state");
        tick();
        tick();
        reset = 1'b0;
        tick();

        for (int v = 0; v < 8; v++) begin
            run_vec(vt[v].d, 0, 0, lat0, lat1, r0, e0, nd);
            check($sformatf("vec%0d latency iters4", v), lat0, vt[v].lat0);
            check($sformatf("vec%0d latency iters1", v), lat1, vt[v].lat1);
            check($sformatf("vec%0d seed rightMux", v), int'(r0), int'(vt[v].rm));
            check($sformatf("vec%0d err", v), int'(e0), int'(vt[v].er));
            check($sformatf("vec%0d done count", v), nd, 1);
        end

        // Start re-pulsed while busy must not disturb the run
        run_vec(16'hC000, 3, 7, lat0, lat1, r0, e0, nd);
        check("repulse latency", lat0, 11);
        check("repulse done count", nd, 1);

        // Reset during ITER_N of pair 2, then a fresh run
        divisor = 16'hC000;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("pre-reset in ITER_N", int'(ns[0]), 1);
        async_reset_pulse();
        tick();
        run_vec(16'hFFFF, 0, 0, lat0, lat1, r0, e0, nd);
        check("post-reset rightMux", int'(r0), 3);
        check("post-reset latency", lat0, 11);
        check("post-reset done count", nd, 1);

        // Back-to-back with start held high
        divisor = 16'h8000;
        start = 1'b1;
        last = -1;
        cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (dn[0] === 1'b1) begin
                if (last >= 0) check("b2b period", c - last, 12);
                else check("b2b first done", c, 11);
                last = c;
                cnt++;
            end
        end
        check("b2b done count", cnt, 3);
        start = 1'b0;
        repeat (14) tick();

        // Random traffic with occasional asynchronous resets
        for (int c = 0; c < 600; c++) begin
            start = ($urandom_range(0, 2) == 0);
            divisor = 16'($urandom);
            if ($urandom_range(0, 70) == 0) async_reset_pulse();
            else tick();
        end
        start = 1'b0;
        repeat (14) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_control.md
DIV_CONTROL -- requirements
Module: div_control

Interface
REQ-001 Parameter: ITERS, default 4, number of refinement (D,N) iteration pairs after the seed pair; legal range 1..7.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; one clock, reset asynchronous active-high.
REQ-004 start  input  1  request a new division; sampled only in IDLE.
REQ-005 divisor  input  16  divisor operand B, Q1.15 normalized (bit 15 expected 1); sampled with start.
REQ-006 kSave  output  1  load divider K register.
REQ-007 dSave  output  1  load divider D register.
REQ-008 nSave  output  1  load divider N register.
REQ-009 kNextSel  output  1  1 = K path takes initial-approximation mux, 0 = K path takes (2 - D) feedback.
REQ-010 rightMux  output  2  initial-approximation table index (IA0..IA3) during seed cycles, 2'b00 otherwise.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 err  output  1  valid with done; 1 = divisor unnormalized (bit 15 = 0), no iterations run.

Function
REQ-014 States: IDLE, SEED_D, SEED_N, ITER_D, ITER_N, DONE; Moore outputs decoded from state only.
REQ-015 IDLE: all control outputs 0; start=1 at an edge latches divisor[15:13] and moves to SEED_D, or to DONE with err=1 if divisor[15]=0.
REQ-016 IA index = latched divisor[14:13]: 00->IA0(0.9), 01->IA1(0.73), 10->IA2(0.62), 11->IA3(0.54).
REQ-017 SEED_D: kSave=1, dSave=1, nSave=0, kNextSel=1, rightMux=IA index; next SEED_N.
REQ-018 SEED_N: kSave=0, dSave=0, nSave=1, kNextSel=1, rightMux=IA index; clears iteration counter; next ITER_D.
REQ-019 ITER_D: kSave=1, dSave=1, nSave=0, kNextSel=0, rightMux=00; next ITER_N.
REQ-020 ITER_N: nSave=1, others 0, kNextSel=0; increments 3-bit counter; next DONE when counter reaches ITERS-1 before increment, else ITER_D.
REQ-021 DONE: done=1 for exactly one cycle, err held from latch, all save strobes 0; next IDLE unconditionally.
REQ-022 Latency: start accepted at edge 0 -> done high in cycle 3+2*ITERS (11 for ITERS=4); err path -> done in cycle 1.
REQ-023 start while busy is ignored, not queued; start held high in the DONE cycle is not accepted until IDLE.
REQ-024 Exactly one of {dSave, nSave} is high in every non-IDLE, non-DONE cycle; kSave equals dSave always.
REQ-025 Divisor changes after acceptance have no effect on rightMux or err.
REQ-026 Back-to-back: start high continuously yields one done every 4+2*ITERS cycles (IDLE cycle between runs).

Reset
REQ-027 reset=1 forces IDLE immediately, independent of clk; all outputs 0, counter 0, latched index/err 0.
REQ-028 Reset mid-operation aborts without done pulse; first edge after reset release with start=1 begins a fresh run.

Structure
REQ-029 Shared package div_pkg holds the state enum, rightMux encodings, IA constant values and the ITERS default.
REQ-030 Single flat module; no sub-module (counter and IA index register are inline).

Verification
REQ-031 divisor=16'hC000, start pulse, ITERS=4 -> SEED_D rightMux=2'b10 kNextSel=1; 4 ITER pairs rightMux=00 kNextSel=0; done=1, err=0 in cycle 11.
REQ-032 divisor=16'h4000 -> done=1, err=1 one cycle after start, no save strobe ever asserted.
REQ-033 start re-pulsed in cycles 3 and 7 of a run -> no change to sequence; single done in cycle 11.
REQ-034 reset asserted mid-cycle during ITER_N of pair 2 -> outputs 0 before next edge, no done; new start with divisor=16'hFFFF -> rightMux=2'b11, full run completes.
REQ-035 start held high, divisor=16'h8000 -> done pulses every 12 cycles, rightMux=2'b00 in seed cycles.
REQ-036 ITERS=1 build -> sequence SEED_D, SEED_N, ITER_D, ITER_N, DONE; done in cycle 5.
